// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and FSM encoding for the 7-segment bus reader
//
// Purpose: segment pattern table (abcdefg, seg[6]=a), blank codes and the
//          capture FSM state encoding used by seg7_bcd_capture and
//          seg7_pattern_decode.
// Contents: SEG7_PAT_0..SEG7_PAT_9, SEG7_PAT_BLANK, BCD_BLANK, seg7_state_e.

package seg7_pkg;

  localparam logic [6:0] SEG7_PAT_0     = 7'b1111110;
  localparam logic [6:0] SEG7_PAT_1     = 7'b0110000;
  localparam logic [6:0] SEG7_PAT_2     = 7'b1101101;
  localparam logic [6:0] SEG7_PAT_3     = 7'b1111001;
  localparam logic [6:0] SEG7_PAT_4     = 7'b0110011;
  localparam logic [6:0] SEG7_PAT_5     = 7'b1011011;
  localparam logic [6:0] SEG7_PAT_6     = 7'b1011111;
  localparam logic [6:0] SEG7_PAT_7     = 7'b1110000;
  localparam logic [6:0] SEG7_PAT_8     = 7'b1111111;
  localparam logic [6:0] SEG7_PAT_9     = 7'b1111011;
  localparam logic [6:0] SEG7_PAT_BLANK = 7'b0000000;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COMMIT = 2'd2,
    HOLD   = 2'd3
  } seg7_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// rtl/seg7_pattern_decode.sv - combinational 7-segment pattern to BCD decoder
//
// Purpose: maps an abcdefg pattern back to its BCD digit.
// Ports:
//   seg   in  7  segment pattern, seg[6]=a, active-high
//   bcd   out 4  decoded digit, BCD_BLANK when not a legal digit
//   legal out 1  pattern is one of the ten digit patterns
//   blank out 1  pattern is all segments off

module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       legal,
  output logic       blank
);

  always_comb begin
    bcd   = BCD_BLANK;
    legal = 1'b1;
    blank = (seg == SEG7_PAT_BLANK);
    case (seg)
      SEG7_PAT_0: bcd = 4'd0;
      SEG7_PAT_1: bcd = 4'd1;
      SEG7_PAT_2: bcd = 4'd2;
      SEG7_PAT_3: bcd = 4'd3;
      SEG7_PAT_4: bcd = 4'd4;
      SEG7_PAT_5: bcd = 4'd5;
      SEG7_PAT_6: bcd = 4'd6;
      SEG7_PAT_7: bcd = 4'd7;
      SEG7_PAT_8: bcd = 4'd8;
      SEG7_PAT_9: bcd = 4'd9;
      default:    legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_bcd_capture.sv
// rtl/seg7_bcd_capture.sv - multiplexed 7-segment bus reader with BCD capture
//
// Purpose: synchronises the segment lines and one-hot digit select, waits
//          for each pattern to settle, decodes it and stores it per digit.
//          Flags illegal patterns / multi-hot selects and signals full frames.
// Configuration: define SEG7_ACTIVE_LOW_EN for common-anode panels (segment
//          lines inverted after the synchroniser; dig_sel stays active-high).
// Ports:
//   clk          in   1             system clock, rising edge
//   rst_n        in   1             asynchronous active-low reset
//   seg_in       in   7             segments {a..g}, seg_in[6]=a, async
//   dig_sel      in   NUM_DIGITS    one-hot digit select, 0 = blanking, async
//   bcd_out      out  4*NUM_DIGITS  digit i at [4i+3:4i], 4'hF = blank/illegal
//   digit_valid  out  NUM_DIGITS    last commit to digit i was a legal 0-9
//   frame_done   out  1             pulse: every digit committed since last pulse
//   err_pulse    out  1             pulse: illegal pattern or multi-hot select

module seg7_bcd_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_done,
  output logic                    err_pulse
);

  localparam int W = NUM_DIGITS + 7;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [W-1:0]          sync1_q, sync2_q, synced, cap_q;
  logic [CNT_W-1:0]      cnt_q;
  seg7_state_e           state_q, state_d;
  logic                  changed, commit_now;
  logic [NUM_DIGITS-1:0] cap_dsel, seen_q, seen_next;
  logic [3:0]            dec_bcd;
  logic                  dec_legal, dec_blank;
  logic                  dsel_zero, dsel_onehot;

  // Two-flop synchroniser on the whole bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {dig_sel, seg_in};
      sync2_q <= sync1_q;
    end
  end

`ifdef SEG7_ACTIVE_LOW_EN
  assign synced = {sync2_q[W-1:7], ~sync2_q[6:0]};
`else
  assign synced = sync2_q;
`endif

  assign changed   = (synced != cap_q);
  assign cap_dsel  = cap_q[W-1:7];
  assign dsel_zero   = (cap_dsel == '0);
  assign dsel_onehot = $onehot(cap_dsel);
  assign seen_next = seen_q | cap_dsel;

  seg7_pattern_decode u_decode (
    .seg   (cap_q[6:0]),
    .bcd   (dec_bcd),
    .legal (dec_legal),
    .blank (dec_blank)
  );

  // Any change restarts settling, whatever the current state. The digit
  // write lands on the edge that enters COMMIT, which gives the
  // STABLE_CYCLES+3 pin-to-output latency.
  always_comb begin
    state_d    = state_q;
    commit_now = 1'b0;
    if (changed) begin
      state_d = SETTLE;
    end else begin
      case (state_q)
        IDLE:   state_d = IDLE;
        SETTLE: begin
          if (cnt_q == CNT_LAST) begin
            state_d    = COMMIT;
            commit_now = 1'b1;
          end
        end
        COMMIT: state_d = HOLD;
        HOLD:   state_d = HOLD;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q <= '0;
      cnt_q <= '0;
    end else if (changed) begin
      cap_q <= synced;
      cnt_q <= '0;
    end else if (state_q == SETTLE) begin
      cnt_q <= commit_now ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_out     <= {NUM_DIGITS{BCD_BLANK}};
      digit_valid <= '0;
      seen_q      <= '0;
      frame_done  <= 1'b0;
      err_pulse   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      err_pulse  <= 1'b0;
      if (commit_now && !dsel_zero) begin
        if (!dsel_onehot) begin
          err_pulse <= 1'b1;
        end else begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cap_dsel[i]) begin
              bcd_out[4*i +: 4] <= dec_legal ? dec_bcd : BCD_BLANK;
              digit_valid[i]    <= dec_legal;
            end
          end
          // All-off is what the encoder drives for non-BCD input: blank, not an error
          if (!dec_legal && !dec_blank) begin
            err_pulse <= 1'b1;
          end
          // The completing digit is not carried into the next frame
          if (&seen_next) begin
            frame_done <= 1'b1;
            seen_q     <= '0;
          end else begin
            seen_q <= seen_next;
          end
        end
      end
    end
  end

endmodule
